// File: rtl/matrix_arbiter.sv
// Round-robin arbiter granting two requesters onto one shared matrix-vector engine.
// Define MATRIX_ARB_TIMEOUT_EN to add a RUN-state timeout that returns rsp_err=1.
module matrix_arbiter #(
  parameter int W        = 8,
  parameter int R        = 3,
  parameter int C        = 3,
  parameter int HOLD_CYC = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [W*C-1:0]       req0_x,
  input  logic [W*R*C-1:0]     req0_m,
  input  logic [W*R-1:0]       req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [W*C-1:0]       req1_x,
  input  logic [W*R*C-1:0]     req1_m,
  input  logic [W*R-1:0]       req1_b,
  output logic                 rsp0_valid,
  output logic [3*W*R-1:0]     rsp0_y,
  output logic                 rsp1_valid,
  output logic [3*W*R-1:0]     rsp1_y,
  output logic                 rsp_err,
  output logic                 eng_hold,
  output logic [W*C-1:0]       eng_x,
  output logic [W*R*C-1:0]     eng_m,
  output logic [W*R-1:0]       eng_b,
  input  logic [3*W*R-1:0]     eng_y,
  input  logic                 eng_done,
  output logic                 busy
);

  localparam int XW  = W*C;
  localparam int MW  = W*R*C;
  localparam int BW  = W*R;
  localparam int YW  = 3*W*R;
  localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  if (HOLD_CYC < 1 || TIMEOUT < 1) begin : g_param_check
    $error("matrix_arbiter: HOLD_CYC and TIMEOUT must be at least 1");
  end

  logic [1:0]     state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [XW-1:0]  x_q, x_d;
  logic [MW-1:0]  m_q, m_d;
  logic [BW-1:0]  b_q, b_d;
  logic [YW-1:0]  y0_q, y0_d;
  logic [YW-1:0]  y1_q, y1_d;
  logic           v0_q, v0_d;
  logic           v1_q, v1_d;

`ifdef MATRIX_ARB_TIMEOUT_EN
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TCW-1:0] run_cnt_q, run_cnt_d;
  logic           err_q, err_d;
`endif

  logic idle;
  logic win1;
  logic xfer;

  assign idle = (state_q == S_IDLE);

  // Both valid: the side not granted last wins; otherwise whichever is valid.
  always_comb begin
    if (req0_valid && req1_valid) win1 = ~last_q;
    else                          win1 = req1_valid;
  end

  assign req0_ready = !reset && idle && req0_valid && !win1;
  assign req1_ready = !reset && idle && req1_valid &&  win1;
  assign xfer       = req0_ready || req1_ready;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    x_d        = x_q;
    m_d        = m_q;
    b_d        = b_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    v0_d       = 1'b0;
    v1_d       = 1'b0;
`ifdef MATRIX_ARB_TIMEOUT_EN
    run_cnt_d  = run_cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d    = S_LOAD;
          hold_cnt_d = '0;
          owner_d    = win1;
          last_d     = win1;
          x_d        = win1 ? req1_x : req0_x;
          m_d        = win1 ? req1_m : req0_m;
          b_d        = win1 ? req1_b : req0_b;
        end
      end
      S_LOAD: begin
        if (hold_cnt_q == HCW'(HOLD_CYC - 1)) begin
          state_d = S_RUN;
`ifdef MATRIX_ARB_TIMEOUT_EN
          run_cnt_d = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      S_RUN: begin
        if (eng_done) begin
          state_d = S_IDLE;
          if (owner_q) begin
            y1_d = eng_y;
            v1_d = 1'b1;
          end else begin
            y0_d = eng_y;
            v0_d = 1'b1;
          end
        end
`ifdef MATRIX_ARB_TIMEOUT_EN
        // Timeout pulses the owner's valid but leaves its result untouched.
        else if (run_cnt_q == TCW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          if (owner_q) v1_d = 1'b1;
          else         v0_d = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + TCW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      x_q        <= '0;
      m_q        <= '0;
      b_q        <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
`ifdef MATRIX_ARB_TIMEOUT_EN
      run_cnt_q  <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      x_q        <= x_d;
      m_q        <= m_d;
      b_q        <= b_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
`ifdef MATRIX_ARB_TIMEOUT_EN
      run_cnt_q  <= run_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Outputs are forced to their reset values for the whole time reset is high.
  assign busy       = !reset && !idle;
  assign eng_hold   = reset || (state_q != S_RUN);
  assign eng_x      = reset ? '0 : x_q;
  assign eng_m      = reset ? '0 : m_q;
  assign eng_b      = reset ? '0 : b_q;
  assign rsp0_valid = !reset && v0_q;
  assign rsp1_valid = !reset && v1_q;
  assign rsp0_y     = reset ? '0 : y0_q;
  assign rsp1_y     = reset ? '0 : y1_q;

`ifdef MATRIX_ARB_TIMEOUT_EN
  assign rsp_err = !reset && err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/matrix_arbiter.md
MATRIX_ARBITER -- requirements
Module: matrix_arbiter

Interface
REQ-001 Parameters SHALL be:
- W, 8, element width (signed).
- R, 3, matrix rows.
- C, 3, matrix columns.
- HOLD_CYC, 2, engine clear cycles (minimum 1).
- TIMEOUT, 64, RUN-state cycle limit.

REQ-002 Ports SHALL be:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid/req1_valid  in  1  operand request.
- req0_ready/req1_ready  out  1  operand accept.
- req0_x/req1_x  in  W*C  flattened signed vector, element 0 in LSBs.
- req0_m/req1_m  in  W*R*C  flattened signed matrix, row-major, element 0 in LSBs.
- req0_b/req1_b  in  W*R  flattened signed bias.
- rsp0_valid/rsp1_valid  out  1  result pulse.
- rsp0_y/rsp1_y  out  3*W*R  flattened signed result.
- rsp_err  out  1  timeout flag, qualifies the rsp*_valid pulse.
- eng_hold  out  1  drives the engine's reset; 1 = engine cleared.
- eng_x/eng_m/eng_b  out  W*C/W*R*C/W*R  engine operands.
- eng_y  in  3*W*R  engine result.
- eng_done  in  1  engine completion, level.
- busy  out  1  high in LOAD or RUN.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD and RUN.
REQ-004 In IDLE with any reqN_valid, the block SHALL assert exactly one reqN_ready, combinationally, to the round-robin winner; a transfer occurs on valid&&ready.
REQ-005 Round-robin arbitration:
- With both valid, the requester not granted last SHALL win.
- With one valid, that requester SHALL win.
- The last-grant pointer SHALL update on each transfer.
REQ-006 On transfer, the block SHALL register x, m, b and the requester ID, then enter LOAD.
REQ-007 eng_x/eng_m/eng_b SHALL be driven from those registers and SHALL stay stable through LOAD and RUN.
REQ-008 LOAD SHALL hold eng_hold=1 for exactly HOLD_CYC cycles (cycle counter), then enter RUN.
REQ-009 In RUN, eng_hold SHALL be 0; the first cycle eng_done=1 SHALL capture eng_y into the owner's rspN_y and return to IDLE.
REQ-010 rspN_valid SHALL pulse for exactly one cycle, the cycle after capture.
REQ-011 rspN_y SHALL hold its value until that requester's next response.
REQ-012 A new grant MAY occur in the same cycle as a rsp pulse.
REQ-013 eng_hold SHALL be 1 in IDLE and LOAD.
REQ-014 Latency SHALL be: transfer at cycle t, RUN begins at t+HOLD_CYC+1, rsp pulse 1 cycle after eng_done is sampled.
REQ-015 Requests SHALL NOT be accepted in LOAD or RUN (ready=0).
REQ-016 A requester dropping valid before ready SHALL lose the request with no other effect.
REQ-017 Responses SHALL have no backpressure.
REQ-018 eng_done sampled in IDLE or LOAD SHALL be ignored.

Reset
REQ-019 While reset=1:
- State SHALL be IDLE and the last-grant pointer SHALL be 1, so req0 wins first.
- Counters, operand registers, rsp*_y and all outputs SHALL be 0, except eng_hold=1.
REQ-020 Reset during LOAD or RUN SHALL discard the in-flight request with no rsp pulse.

Configuration
REQ-021 Macro MATRIX_ARB_TIMEOUT_EN defined:
- A RUN cycle counter SHALL run.
- If eng_done is not seen within TIMEOUT cycles, the block SHALL return to IDLE, pulse the owner's rspN_valid with rsp_err=1 and leave rspN_y unchanged.
REQ-022 Macro MATRIX_ARB_TIMEOUT_EN undefined:
- No timeout counter SHALL exist.
- rsp_err SHALL be constant 0.
- RUN SHALL wait indefinitely.

Verification
REQ-023 The bench SHALL cover, with the W=8, R=3, C=3 engine:
- Single request: req0 with x={1,1,1}, M={1,-1,0; 1,1,0; 0,0,1}, b={0,0,1} -> one rsp0_valid pulse, rsp0_y={0,2,2}; rsp1_valid stays 0.
- Simultaneous requests from reset: req0 and req1 valid in the same cycle -> req0 served first, req1 next, with the rsp0 pulse before the rsp1 pulse.
- Fairness: both requesters held valid for 4 transactions -> grants alternate 0,1,0,1.
- Latency: with HOLD_CYC=2, eng_hold is 1 for exactly 2 cycles after transfer, and rsp pulses exactly 1 cycle after eng_done rises.
- Reset mid-RUN: no rsp pulse, eng_hold=1, busy=0, and the next grant goes to req0.
- With MATRIX_ARB_TIMEOUT_EN and eng_done tied 0: rsp_err and rsp0_valid pulse together TIMEOUT cycles into RUN; without the macro, busy stays 1.
